// File: rtl/data_sram_like_slave.sv
// Data-port memory responder on the sram-like req/addr_ok/data_ok handshake.
// Byte-strobed stores, full-word read snapshots, fixed-latency in-order responses.
module data_sram_like_slave #(
    parameter int AW       = 12,
    parameter int RESP_LAT = 2,
    parameter int MAX_OUT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        addr_stall,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        err_misalign
);

    localparam int   PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int   DEPTH = 1 << AW;
    localparam logic USE_Q = 1'(RESP_LAT > 1);

    logic [31:0]   mem_r    [0:DEPTH-1];
    logic [31:0]   q_data_r [0:MAX_OUT-1];
    logic [3:0]    q_age_r  [0:MAX_OUT-1];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [3:0]    count_r;
    logic          data_ok_r;
    logic [31:0]   rdata_r;
    logic          err_r;

    logic [AW-1:0] word_idx_s;
    logic [31:0]   old_word_s;
    logic [3:0]    strobe_s;
    logic [31:0]   mask_s;
    logic          misalign_s;
    logic [31:0]   snap_s;
    logic          accept_s;
    logic          push_s;
    logic          retire_s;
    logic          unused_s;

    function automatic logic [3:0] strobe_f(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    strobe_f = 4'b0001 << lane;
            2'd1:    strobe_f = lane[1] ? 4'b1100 : 4'b0011;
            default: strobe_f = 4'b1111;
        endcase
    endfunction

    function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    misalign_f = 1'b0;
            2'd1:    misalign_f = lane[0];
            default: misalign_f = (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc_f(input logic [PW-1:0] ptr);
        if (ptr == PW'(MAX_OUT - 1)) begin
            ptr_inc_f = {PW{1'b0}};
        end else begin
            ptr_inc_f = ptr + PW'(1);
        end
    endfunction

    assign word_idx_s   = data_addr[AW+1:2];
    assign old_word_s   = mem_r[word_idx_s];
    assign unused_s     = ^{data_addr[31:AW+2]};
    // A slot freed by a retirement only becomes visible on the following cycle.
    assign data_addr_ok = !addr_stall && (count_r < 4'(MAX_OUT));
    assign accept_s     = data_req && data_addr_ok && !reset;
    assign push_s       = accept_s && USE_Q;
    assign retire_s     = (count_r != 4'd0) && (q_age_r[rd_ptr_r] == 4'(RESP_LAT - 1));

    // Strobe decode and the word a request will report (post-write for stores).
    always_comb begin
        strobe_s   = strobe_f(data_size, data_addr[1:0]);
        misalign_s = misalign_f(data_size, data_addr[1:0]);
        mask_s     = {{8{strobe_s[3]}}, {8{strobe_s[2]}}, {8{strobe_s[1]}}, {8{strobe_s[0]}}};
        if (data_wr && !misalign_s) begin
            snap_s = (old_word_s & ~mask_s) | (data_wdata & mask_s);
        end else begin
            snap_s = old_word_s;
        end
    end

    // Word array; merged word written back so only strobed bytes change.
    always_ff @(posedge clk) begin
        if (accept_s && data_wr && !misalign_s) begin
            mem_r[word_idx_s] <= snap_s;
        end
    end

    // Response queue payload; age counts accepting-edge-inclusive edges per entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUT; i++) begin
            q_age_r[i] <= q_age_r[i] + 4'd1;
        end
        if (push_s) begin
            q_data_r[wr_ptr_r] <= snap_s;
            q_age_r[wr_ptr_r]  <= 4'd1;
        end
    end

    // Queue control, response outputs and the sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= 4'd0;
            data_ok_r <= 1'b0;
            rdata_r   <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            if (accept_s && misalign_s) begin
                err_r <= 1'b1;
            end
            if (push_s) begin
                wr_ptr_r <= ptr_inc_f(wr_ptr_r);
            end
            if (retire_s) begin
                rd_ptr_r <= ptr_inc_f(rd_ptr_r);
            end
            case ({push_s, retire_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
            // Single-cycle latency bypasses the queue entirely.
            if (!USE_Q) begin
                data_ok_r <= accept_s;
                if (accept_s) begin
                    rdata_r <= snap_s;
                end
            end else begin
                data_ok_r <= retire_s;
                if (retire_s) begin
                    rdata_r <= q_data_r[rd_ptr_r];
                end
            end
        end
    end

    assign data_data_ok = data_ok_r;
    assign data_rdata   = rdata_r;
    assign err_misalign = err_r;

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Directed bench for data_sram_like_slave: instance a (RESP_LAT=2) and b (RESP_LAT=6).
module tb_data_sram_like_slave;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [2];
    logic        wr    [2];
    logic        stall [2];
    logic [1:0]  size  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        aok   [2];
    logic        dok   [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;
    vec_t vecs [13];

    always #5 clk = ~clk;

    data_sram_like_slave #(.AW(12), .RESP_LAT(2), .MAX_OUT(4)) dut_a (
        .clk(clk), .reset(reset), .data_req(req[0]), .data_wr(wr[0]), .data_size(size[0]),
        .data_addr(addr[0]), .data_wdata(wdata[0]), .addr_stall(stall[0]),
        .data_addr_ok(aok[0]), .data_rdata(rdata[0]), .data_data_ok(dok[0]), .err_misalign(err[0])
    );

    data_sram_like_slave #(.AW(12), .RESP_LAT(6), .MAX_OUT(4)) dut_b (
        .clk(clk), .reset(reset), .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
        .data_addr(addr[1]), .data_wdata(wdata[1]), .addr_stall(stall[1]),
        .data_addr_ok(aok[1]), .data_rdata(rdata[1]), .data_data_ok(dok[1]), .err_misalign(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] wd);
        req[d]   = r;
        wr[d]    = w;
        size[d]  = s;
        addr[d]  = a;
        wdata[d] = wd;
    endtask

    // One isolated request; data_ok expected on the lat-th negedge after acceptance.
    task automatic single(input int d, input int lat, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        @(negedge clk);
        chk({tag, "_aok"}, 32'(aok[d]), 32'd1);
        drive(d, 1'b1, w, s, a, wd);
        @(negedge clk);
        req[d] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            if (k < lat) begin
                chk({tag, "_early_dok"}, 32'(dok[d]), 32'd0);
            end else begin
                chk({tag, "_dok"}, 32'(dok[d]), 32'd1);
                chk({tag, "_rdata"}, rdata[d], exp_rd);
                chk({tag, "_err"}, 32'(err[d]), 32'(exp_err));
            end
        end
        @(negedge clk);
        chk({tag, "_dok_drop"}, 32'(dok[d]), 32'd0);
    endtask

    initial begin
        logic [9:0]  exp_ok;
        logic [19:0] exp_dok;
        logic [31:0] sb [$];
        logic [31:0] want;
        int idx;
        int resp;

        vecs[0]  = '{1'b1, 2'd2, 32'h100, 32'h11223344, 32'h11223344, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 32'h100, 32'h00000000, 32'h11223344, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 32'h200, 32'h00000000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 32'h201, 32'h0000AA00, 32'h0000AA00, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 32'h202, 32'hBEEF0000, 32'hBEEFAA00, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 32'h200, 32'h00000000, 32'hBEEFAA00, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 32'h203, 32'h12345678, 32'h12EFAA00, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 32'h200, 32'hCAFED00D, 32'h12EFD00D, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 32'h300, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 32'h303, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b1, 2'd2, 32'h102, 32'hFFFFFFFF, 32'h11223344, 1'b1};
        vecs[11] = '{1'b0, 2'd2, 32'h100, 32'h00000000, 32'h11223344, 1'b1};
        vecs[12] = '{1'b1, 2'd1, 32'h301, 32'h00000000, 32'hA5A5A5A5, 1'b1};

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            stall[d] = 1'b0;
            drive(d, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_dok", 32'(dok[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_aok", 32'(aok[d]), 32'd1);
        end

        for (int i = 0; i < 13; i++) begin
            single(0, 2, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Back-to-back store then load of the same word.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'd2, 32'h104, 32'h55667788);
        @(negedge clk);
        chk("b2b_aok", 32'(aok[0]), 32'd1);
        chk("b2b_dok0", 32'(dok[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 2'd2, 32'h104, 32'd0);
        @(negedge clk);
        req[0] = 1'b0;
        chk("b2b_dok1", 32'(dok[0]), 32'd1);
        chk("b2b_rd1", rdata[0], 32'h55667788);
        @(negedge clk);
        chk("b2b_dok2", 32'(dok[0]), 32'd1);
        chk("b2b_rd2", rdata[0], 32'h55667788);
        @(negedge clk);
        chk("b2b_dok3", 32'(dok[0]), 32'd0);

        // Stall for three cycles with a load pending.
        @(negedge clk);
        stall[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 2'd2, 32'h200, 32'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_aok", 32'(aok[0]), 32'd0);
            @(negedge clk);
            chk("stall_dok", 32'(dok[0]), 32'd0);
        end
        stall[0] = 1'b0;
        #1;
        chk("unstall_aok", 32'(aok[0]), 32'd1);
        @(negedge clk);
        req[0] = 1'b0;
        chk("unstall_dok0", 32'(dok[0]), 32'd0);
        @(negedge clk);
        chk("unstall_dok1", 32'(dok[0]), 32'd1);
        chk("unstall_rd", rdata[0], 32'h12EFD00D);
        chk("err_sticky", 32'(err[0]), 32'd1);

        // Full queue on instance b: req held high for ten cycles.
        exp_ok  = 10'b1111001111;
        exp_dok = 20'b0000_1111_0011_1100_0000;
        idx  = 0;
        resp = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 10) begin
                chk($sformatf("full_aok_c%0d", c), 32'(aok[1]), 32'(exp_ok[c]));
                drive(1, 1'b1, 1'b1, 2'd2, 32'(idx * 4), 32'hB0000000 + 32'(idx));
                if (aok[1]) begin
                    sb.push_back(32'hB0000000 + 32'(idx));
                    idx++;
                end
            end else begin
                req[1] = 1'b0;
            end
            chk($sformatf("full_dok_c%0d", c), 32'(dok[1]), 32'(exp_dok[c]));
            if (dok[1]) begin
                resp++;
                want = (sb.size() > 0) ? sb.pop_front() : 32'hDEADDEAD;
                chk($sformatf("full_order_c%0d", c), rdata[1], want);
            end
        end
        chk("full_accepts", 32'(idx), 32'd8);
        chk("full_responses", 32'(resp), 32'd8);

        // Reset with one store and three loads outstanding on instance b.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2'd2, 32'h40, 32'h5A5A0001);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("prerst_aok", 32'(aok[1]), 32'd1);
            drive(1, 1'b1, 1'b0, 2'd2, 32'h40, 32'd0);
        end
        @(negedge clk);
        req[1] = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_aok", 32'(aok[1]), 32'd1);
        chk("midrst_rdata", rdata[1], 32'd0);
        chk("midrst_err_a", 32'(err[0]), 32'd0);
        for (int c = 0; c < 10; c++) begin
            chk("midrst_no_dok", 32'(dok[1]), 32'd0);
            @(negedge clk);
        end
        single(1, 6, 1'b0, 2'd2, 32'h40, 32'd0, 32'h5A5A0001, 1'b0, "post_rst_load");
        single(0, 2, 1'b0, 2'd2, 32'h100, 32'd0, 32'h11223344, 1'b0, "post_rst_a");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
